uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter: the next-generation replacement for the fixed 8N1 transmitter in the EN2111 UART datapath. It accepts words through a valid/ready handshake into a small FIFO and serialises them LSB-first. Data width, FIFO depth, and baud divisor width are compile-time parameters. Bit period, parity mode and stop-bit count are run-time configuration inputs. Back-to-back frames are emitted with no idle gap.

## Interface

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- FIFO_DEPTH, 4: words of buffering. Must be a power of two, at least 2.
- DIV_W, 16: width of the bit-period divisor input.

Ports:
- clk, input, 1: single system clock. All logic is on the rising edge.
- rstn, input, 1: asynchronous, active-low reset.
- s_valid, input, 1: the upstream word on s_data is valid.
- s_data, input, DATA_BITS: word to transmit.
- s_ready, output, 1: the FIFO can accept a word this cycle.
- cfg_div, input, DIV_W: clocks per bit minus 1, so bit period D = cfg_div+1 (range 1..2^DIV_W).
- cfg_parity, input, 2: parity mode. 00 = none, 01 = even, 10 = odd, 11 = none.
- cfg_stop2, input, 1: 0 selects one stop bit, 1 selects two.
- tx, output, 1: serial line. Registered output; idles high.
- busy, output, 1: high while a frame is on the line (state != IDLE).
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of words currently buffered.

## Operation

- **Handshake and FIFO write**
  - A word is accepted on a rising edge where s_valid && s_ready.
  - s_ready = (fifo_count < FIFO_DEPTH).
  - There is no same-cycle bypass: when the FIFO is full, s_ready is 0 even in a cycle where a pop occurs.
- **FIFO pointers and count**
  - Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_count increments on push, decrements on pop, and is unchanged when push and pop occur in the same cycle.
- **Configuration latching**
  - cfg_div, cfg_parity and cfg_stop2 are latched when a word is popped.
  - Changes to these inputs mid-frame do not affect the frame in progress.
- **Parity**
  - Even parity: the parity bit is the XOR of the data bits.
  - Odd parity: the parity bit is the inverse of that XOR.
  - Parity is computed over the popped word at load time.
- **State machine** (state changes only at the end of a bit period, when bit counter = D-1; the bit counter clears at every state change):
  - IDLE: tx = 1. If fifo_count != 0, pop the head into the shift register, latch config, set tx <= 0 and go to START.
  - START: go to DATA and drive shift[0].
  - DATA: after DATA_BITS bits, go to PARITY if parity is enabled, otherwise STOP. Shift right once per bit.
  - PARITY: drive the parity bit, then go to STOP.
  - STOP: drive tx = 1 for 1 or 2 bit periods. On completion:
    - if fifo_count != 0, pop the next word and go directly to START with tx <= 0 (zero-gap back-to-back);
    - otherwise go to IDLE.
- **Frame length**: D × (1 + DATA_BITS + P + S) clocks, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the stop-bit count.
- **Reset** (asynchronous, may be asserted mid-frame): tx = 1 immediately, FIFO flushed, state = IDLE.

## Timing

Reset values:
- tx = 1, s_ready = 1, busy = 0, fifo_count = 0.
- All pointers and counters are 0.
- The latched configuration is all zeros.

Latency:
- A word accepted at edge N (FIFO empty, IDLE) gives fifo_count = 1 after N.
- tx goes low after edge N+1, and busy rises after edge N+1.

Bit timing:
- Every bit, including start and stop, is held for exactly D clock cycles.
- busy falls on the same edge at which tx has completed its last stop-bit period and the FIFO is empty.

Boundary conditions:
- With D = 1, one bit is sent per clock and back-to-back frames stay contiguous.
- Pushing into a full FIFO is impossible, because s_ready = 0.
- A pop from an empty FIFO never occurs.

## Test plan

- **8N1, single word**: DATA_BITS=8, cfg_div=3, parity none, one stop bit. Push 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. Frame lasts 40 clocks, and busy is high for exactly 40 cycles.
- **Parity**: cfg_div=1. Push 0x07 with even parity → parity bit = 1, frame is 11 bits / 22 clocks. Repeat with odd parity → parity bit = 0.
- **Two stop bits**: push 0xFF with cfg_stop2=1 and D=4 → tx stays high for 8 clocks after the data bits, then goes to IDLE.
- **Back-to-back and full FIFO**: FIFO_DEPTH=4, D=2. Assert s_valid with 6 words 0x01..0x06 on consecutive cycles.
  - s_ready drops once fifo_count reaches 4.
  - All six frames are sent contiguously: no idle cycle, 20 clocks each, 120 clocks total.
  - Output order is 0x01..0x06.
- **Mid-frame configuration change**: start 0x3C with D=4, then change cfg_div to 7 after the start bit → the whole frame still uses 4 clocks/bit. The next frame uses 8 clocks/bit.
- **Reset mid-frame**: with 3 words queued, assert rstn=0 during the DATA state → tx=1, fifo_count=0 and busy=0 with no clock edge required. After release, no frame is emitted.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
//==============================================================================
// Module      : uart_tx_fifo_if
// Description : Valid/ready word handshake into the buffered UART transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  // Upstream producer side
  modport master (output s_valid, output s_data, input s_ready);
  // Transmitter side
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. Words enter a small FIFO through a
//               valid/ready handshake and are serialised LSB-first with
//               run-time bit period, parity mode and stop-bit count.
//               Back-to-back frames leave the line with no idle gap.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  wire                        clk,
  input  wire                        rstn,
  uart_tx_fifo_if.slave              s,
  input  wire  [DIV_W-1:0]           cfg_div,
  input  wire  [1:0]                 cfg_parity,
  input  wire                        cfg_stop2,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 w_push;
  logic                 w_load;
  logic [DATA_BITS-1:0] w_head;

  // Serialiser state
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tx_q, tx_d;
  logic                 w_bit_end;

  // Full FIFO refuses writes even if a pop happens this cycle (no bypass)
  assign s.s_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign w_push     = s.s_valid && s.s_ready;
  assign w_head     = mem_q[rd_ptr_q];
  assign w_bit_end  = (cnt_q == div_q);

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;

  // FIFO data array write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= s.s_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_load) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_load})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser state register; tx returns high the instant reset asserts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state: bit timing, frame sequencing and head-of-FIFO loading
  always_comb begin
    state_d    = state_q;
    cnt_d      = w_bit_end ? '0 : cnt_q + DIV_W'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    tx_d       = tx_q;
    w_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (count_q != '0) w_load = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            // Next data bit is the one just above the bit now on the line
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (count_q != '0) begin
            w_load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Pop the head word, snapshot configuration and begin the start bit
    if (w_load) begin
      shift_d    = w_head;
      div_d      = cfg_div;
      stop2_d    = cfg_stop2;
      par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d  = (^w_head) ^ (cfg_parity == 2'b10);
      state_d    = S_START;
      cnt_d      = '0;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      tx_d       = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//==============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based line model
//               predicts tx/busy/fifo_count/s_ready every cycle; directed
//               frames are also pinned against hand-computed bit patterns.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic                        clk = 1'b0;
  logic                        rstn = 1'b0;
  logic [DIV_W-1:0]            cfg_div;
  logic [1:0]                  cfg_parity;
  logic                        cfg_stop2;
  logic                        tx;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo_if #(.DATA_BITS(DATA_BITS)) sif();

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s         (sif),
    .cfg_div   (cfg_div),
    .cfg_parity(cfg_parity),
    .cfg_stop2 (cfg_stop2),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  bit  cmp_en = 1'b0;
  bit  saw_stall = 1'b0;

  // Reference model: buffered words plus the remaining line waveform
  logic [DATA_BITS-1:0] mq[$];
  bit                   wave[$];
  logic                 m_tx = 1'b1;
  logic                 m_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expand one frame into per-clock line levels
  function automatic void gen_frame(input logic [DATA_BITS-1:0] w, input logic [DIV_W-1:0] div,
                                    input logic [1:0] par, input logic st2);
    bit fb[$];
    int d;
    d = int'(div) + 1;
    fb.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) fb.push_back(w[i]);
    if (par == 2'b01) fb.push_back(^w);
    if (par == 2'b10) fb.push_back(~(^w));
    fb.push_back(1'b1);
    if (st2) fb.push_back(1'b1);
    foreach (fb[k]) for (int r = 0; r < d; r++) wave.push_back(fb[k]);
  endfunction

  // Model step: a new frame starts whenever the line is free and a word waits
  initial begin
    bit                   do_push;
    logic [DATA_BITS-1:0] pw;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        mq.delete();
        wave.delete();
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end else begin
        do_push = sif.s_valid && (mq.size() < FIFO_DEPTH);
        pw      = sif.s_data;
        if (wave.size() == 0 && mq.size() != 0)
          gen_frame(mq.pop_front(), cfg_div, cfg_parity, cfg_stop2);
        if (do_push) mq.push_back(pw);
        if (wave.size() != 0) begin
          m_tx   = wave.pop_front();
          m_busy = 1'b1;
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("tx", tx, m_tx);
        chk("busy", busy, m_busy);
        chk("fifo_count", fifo_count, mq.size());
        chk("s_ready", sif.s_ready, (mq.size() < FIFO_DEPTH));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; s_valid is left high
  task automatic push_word(input logic [DATA_BITS-1:0] w);
    int g;
    g = 0;
    sif.s_data  = w;
    sif.s_valid = 1'b1;
    while (!sif.s_ready && g < 2000) begin
      if (fifo_count == FIFO_DEPTH) saw_stall = 1'b1;
      tick(1);
      g++;
    end
    chk("push_ready", sif.s_ready, 1'b1);
    tick(1);
  endtask

  // Record one busy window; bits[k] is the level at the start of bit k
  task automatic capture(input int d, output int nb, output logic [63:0] bits, output int glitch);
    logic samp [0:1023];
    int   g, n;
    g = 0; n = 0; bits = '0; glitch = 0;
    do begin @(negedge clk); g++; end while (!busy && g < 1000);
    chk("busy_rise", busy, 1'b1);
    while (busy && n < 1024) begin
      samp[n] = tx;
      n++;
      @(negedge clk);
    end
    nb = n;
    for (int i = 0; i < n; i++) begin
      if (i % d == 0) begin
        if (i / d < 64) bits[i / d] = samp[i];
      end else if (samp[i] !== samp[i - (i % d)]) begin
        glitch++;
      end
    end
  endtask

  initial begin
    int          nb, gl, seen;
    logic [63:0] bits;

    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    cfg_div     = 16'd3;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    rstn        = 1'b0;
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", sif.s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    rstn   = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // 8N1, D=4, 0xA5
    push_word(8'hA5);
    sif.s_valid = 1'b0;
    capture(4, nb, bits, gl);
    chk("8n1_len", nb, 40);
    chk("8n1_bits", bits[9:0], 10'b1101001010);
    chk("8n1_hold", gl, 0);
    tick(2);

    // Even then odd parity, D=2, 0x07
    cfg_div = 16'd1; cfg_parity = 2'b01;
    push_word(8'h07);
    sif.s_valid = 1'b0;
    capture(2, nb, bits, gl);
    chk("even_len", nb, 22);
    chk("even_bits", bits[10:0], 11'b11000001110);
    tick(2);
    cfg_parity = 2'b10;
    push_word(8'h07);
    sif.s_valid = 1'b0;
    capture(2, nb, bits, gl);
    chk("odd_len", nb, 22);
    chk("odd_bits", bits[10:0], 11'b10000001110);
    tick(2);

    // Two stop bits, D=4, 0xFF
    cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
    push_word(8'hFF);
    sif.s_valid = 1'b0;
    capture(4, nb, bits, gl);
    chk("stop2_len", nb, 44);
    chk("stop2_bits", bits[10:0], 11'b11111111110);
    cfg_stop2 = 1'b0;
    tick(2);

    // Back-to-back through a full FIFO, D=2
    cfg_div = 16'd1;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) push_word(DATA_BITS'(i));
        sif.s_valid = 1'b0;
      end
      capture(2, nb, bits, gl);
    join
    chk("b2b_len", nb, 120);
    chk("b2b_hold", gl, 0);
    chk("b2b_stall", saw_stall, 1'b1);
    for (int f = 0; f < 6; f++) chk("b2b_order", bits[f*10+1 +: 8], f + 1);
    tick(2);

    // D=1 contiguous frames
    cfg_div = 16'd0;
    fork
      begin
        for (int i = 0; i < 3; i++) push_word(8'h5A ^ DATA_BITS'(i));
        sif.s_valid = 1'b0;
      end
      capture(1, nb, bits, gl);
    join
    chk("d1_len", nb, 30);
    chk("d1_first", bits[8:1], 8'h5A);
    tick(2);

    // Configuration change mid-frame
    cfg_div = 16'd3;
    push_word(8'h3C);
    sif.s_valid = 1'b0;
    fork
      capture(4, nb, bits, gl);
      begin tick(7); cfg_div = 16'd7; end
    join
    chk("cfg_keep_len", nb, 40);
    chk("cfg_keep_bits", bits[9:0], 10'b1001111000);
    chk("cfg_keep_hold", gl, 0);
    tick(2);
    push_word(8'h3C);
    sif.s_valid = 1'b0;
    capture(8, nb, bits, gl);
    chk("cfg_new_len", nb, 80);
    chk("cfg_new_bits", bits[9:0], 10'b1001111000);
    tick(2);

    // Asynchronous reset in the middle of the data bits
    cfg_div = 16'd3;
    for (int i = 0; i < 4; i++) push_word(8'h11 * DATA_BITS'(i + 1));
    sif.s_valid = 1'b0;
    tick(8);
    chk("pre_rst_count", fifo_count, 3);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy, 1'b0);
    tick(3);
    rstn = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("post_rst_idle", seen, 0);
    tick(1);

    // Randomised traffic with configuration churning every cycle
    for (int c = 0; c < 3000; c++) begin
      sif.s_valid = ($urandom_range(0, 9) < 4);
      sif.s_data  = DATA_BITS'($urandom);
      cfg_div     = DIV_W'($urandom_range(0, 3));
      cfg_parity  = 2'($urandom_range(0, 3));
      cfg_stop2   = 1'($urandom_range(0, 1));
      tick(1);
    end
    sif.s_valid = 1'b0;
    seen = 0;
    while ((busy || fifo_count != 0) && seen < 2000) begin
      tick(1);
      seen++;
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_count", fifo_count, 0);
    tick(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
